// File: rtl/mpeg2_task_issuer_if.sv
// Bus bundle between the MPEG2 task issuer and its surroundings: pixel input
// stream, task packet channel, result packet channel and recovered stream words.
// The master modport is the issuer's view; the slave modport is the
// accelerator/host view.
interface mpeg2_task_issuer_if #(
  parameter int TASK_SIZE   = 208,
  parameter int RESULT_SIZE = 336
);
  logic                   pix_valid;
  logic [63:0]            pix_data;
  logic                   pix_ready;
  logic [TASK_SIZE-1:0]   task_data;
  logic                   task_valid;
  logic                   task_ready;
  logic [RESULT_SIZE-1:0] res_data;
  logic                   res_valid;
  logic                   o_en;
  logic [255:0]           o_data;

  modport master (
    input  pix_valid, pix_data, task_ready, res_data, res_valid,
    output pix_ready, task_data, task_valid, o_en, o_data
  );

  modport slave (
    output pix_valid, pix_data, task_ready, res_data, res_valid,
    input  pix_ready, task_data, task_valid, o_en, o_data
  );
endinterface

// File: rtl/mpeg2_task_issuer.sv
// MPEG2 accelerator task issuer: turns a start command and a YUV pixel stream
// into the ordered task packet sequence, forwards stream words carried by
// result packets and reports completion on the stop-marker result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a start with nonzero config
// S_RST_LO | control packet presented, encoder rstn=0
// S_RST_HI | control packet presented, encoder rstn=1
// S_BUFRST | buffer-reset packet presented
// S_SIZE   | size packet presented
// S_PIX    | streaming pixel words, one packet per accepted word
// S_STOP   | control packet with stop=1 presented
// S_WAIT   | waiting for the stop-marker result
module mpeg2_task_issuer #(
  parameter int TASK_SIZE   = 208,
  parameter int RESULT_SIZE = 336,
  parameter int FRAMES_W    = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start_i,
  input  logic [6:0]          cfg_xsize16_i,
  input  logic [6:0]          cfg_ysize16_i,
  input  logic [FRAMES_W-1:0] cfg_frames_i,
  input  logic                abort_i,
  mpeg2_task_issuer_if.master bus,
  output logic                busy_o,
  output logic                done_o,
  output logic [31:0]         words_out_o,
  output logic                stray_res_o
);

  localparam int TOTAL_W = FRAMES_W + 20;

  localparam logic [63:0] ADDR_CTRL   = 64'h0;
  localparam logic [63:0] ADDR_SIZE   = 64'h8;
  localparam logic [63:0] ADDR_BUFRST = 64'h10;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_LO, S_RST_HI, S_BUFRST, S_SIZE, S_PIX, S_STOP, S_WAIT
  } state_e;

  state_e               state_q;
  logic [TASK_SIZE-1:0] task_data_q;
  logic                 task_valid_q;
  logic [63:0]          seq_q;
  logic [63:0]          seq_d;
  logic [6:0]           xsize_q;
  logic [6:0]           ysize_q;
  logic [TOTAL_W-1:0]   pix_left_q;
  logic [23:0]          pix_idx_q;
  logic                 abort_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 stray_q;
  logic                 o_en_q;
  logic [255:0]         o_data_q;
  logic [31:0]          words_q;

  logic [13:0]          area_w;
  logic [19:0]          wpf_w;
  logic [TOTAL_W-1:0]   total_w;
  logic                 cfg_ok_w;
  logic                 accept_w;
  logic                 pix_done_w;
  logic                 pix_ready_w;
  logic                 take_pix_w;
  logic                 res_word_w;
  logic                 res_stop_w;

  function automatic logic [TASK_SIZE-1:0] make_pkt(input logic [63:0] seq,
                                                    input logic [63:0] addr,
                                                    input logic [63:0] payload);
    logic [TASK_SIZE-1:0] p;
    p          = '0;
    p[63:0]    = seq;
    p[143:80]  = addr;
    p[207:144] = payload;
    return p;
  endfunction

  function automatic logic [63:0] ctrl_payload(input logic enc_rstn, input logic stop);
    return {62'd0, stop, enc_rstn};
  endfunction

  // Pixel budget, handshake qualifiers and result classification.
  always_comb begin
    area_w      = 14'(cfg_xsize16_i) * 14'(cfg_ysize16_i);
    wpf_w       = {area_w, 6'd0};
    total_w     = TOTAL_W'(cfg_frames_i) * TOTAL_W'(wpf_w);
    cfg_ok_w    = (cfg_xsize16_i != 7'd0) && (cfg_ysize16_i != 7'd0) && (cfg_frames_i != '0);
    accept_w    = task_valid_q && bus.task_ready;
    seq_d       = seq_q + 64'(accept_w);
    // abort_i is honoured combinationally so no pixel slips in on the abort cycle
    pix_done_w  = (pix_left_q == '0) || abort_q || abort_i;
    pix_ready_w = (state_q == S_PIX) && !pix_done_w && (!task_valid_q || bus.task_ready);
    take_pix_w  = pix_ready_w && bus.pix_valid;
    res_word_w  = bus.res_valid && bus.res_data[0] && !bus.res_data[1];
    res_stop_w  = bus.res_valid && bus.res_data[1];
  end

  // Sequencer, packet register and result path.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      task_data_q  <= '0;
      task_valid_q <= 1'b0;
      seq_q        <= '0;
      xsize_q      <= '0;
      ysize_q      <= '0;
      pix_left_q   <= '0;
      pix_idx_q    <= '0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      stray_q      <= 1'b0;
      o_en_q       <= 1'b0;
      o_data_q     <= '0;
      words_q      <= '0;
    end else begin
      done_q <= 1'b0;
      o_en_q <= 1'b0;
      seq_q  <= seq_d;

      if (state_q != S_IDLE && res_word_w) begin
        o_en_q   <= 1'b1;
        o_data_q <= bus.res_data[335:80];
        if (words_q != 32'hFFFF_FFFF) words_q <= words_q + 32'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.res_valid) stray_q <= 1'b1;
          if (start_i && cfg_ok_w) begin
            xsize_q      <= cfg_xsize16_i;
            ysize_q      <= cfg_ysize16_i;
            pix_left_q   <= total_w;
            pix_idx_q    <= '0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b1;
            stray_q      <= 1'b0;
            words_q      <= '0;
            seq_q        <= '0;
            task_data_q  <= make_pkt(64'd0, ADDR_CTRL, ctrl_payload(1'b0, 1'b0));
            task_valid_q <= 1'b1;
            state_q      <= S_RST_LO;
          end
        end
        S_RST_LO: if (accept_w) begin
          task_data_q <= make_pkt(seq_d, ADDR_CTRL, ctrl_payload(1'b1, 1'b0));
          state_q     <= S_RST_HI;
        end
        S_RST_HI: if (accept_w) begin
          task_data_q <= make_pkt(seq_d, ADDR_BUFRST, 64'd0);
          state_q     <= S_BUFRST;
        end
        S_BUFRST: if (accept_w) begin
          task_data_q <= make_pkt(seq_d, ADDR_SIZE, {25'd0, ysize_q, 25'd0, xsize_q});
          state_q     <= S_SIZE;
        end
        S_SIZE: if (accept_w) begin
          task_valid_q <= 1'b0;
          state_q      <= S_PIX;
        end
        S_PIX: begin
          if (abort_i) abort_q <= 1'b1;
          if (take_pix_w) begin
            task_data_q  <= make_pkt(seq_d, {40'd0, 8'h01, pix_idx_q}, bus.pix_data);
            task_valid_q <= 1'b1;
            pix_idx_q    <= pix_idx_q + 24'd1;
            pix_left_q   <= pix_left_q - TOTAL_W'(1);
          end else if (pix_done_w && (!task_valid_q || accept_w)) begin
            task_data_q  <= make_pkt(seq_d, ADDR_CTRL, ctrl_payload(1'b1, 1'b1));
            task_valid_q <= 1'b1;
            state_q      <= S_STOP;
          end else if (accept_w) begin
            task_valid_q <= 1'b0;
          end
        end
        S_STOP: if (accept_w) begin
          task_valid_q <= 1'b0;
          state_q      <= S_WAIT;
        end
        S_WAIT: if (res_stop_w) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_ready  = pix_ready_w;
  assign bus.task_data  = task_data_q;
  assign bus.task_valid = task_valid_q;
  assign bus.o_en       = o_en_q;
  assign bus.o_data     = o_data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign words_out_o    = words_q;
  assign stray_res_o    = stray_q;

endmodule
